// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
//
// Direct-mapped, write-back, write-allocate data cache for an 8-bit CPU.
// It sits between the CPU datapath and a 32-bit-block data memory. Each of
// the SETS lines holds one 4-byte block.
//
// Load/store hits finish in the access cycle. On a miss, a small memory FSM
// runs: it writes back a dirty victim first if needed, then allocates the
// new block. After one UPDATE cycle it returns to IDLE, where the held
// access replays as a hit.
//
// Optional feature: define CACHE_STATS_EN to add the HIT_COUNT and
// MISS_COUNT statistics outputs. With the macro undefined, those ports and
// their counters do not exist.
//
// Ports
//   CLK            in   1   clock, all state updates on posedge
//   RESET          in   1   asynchronous, active-low reset
//   READ           in   1   CPU load request, held until BUSYWAIT low
//   WRITE          in   1   CPU store request, held until BUSYWAIT low
//   ADDRESS        in   8   byte address {tag[7:5], index[4:2], offset[1:0]}
//   WRITEDATA      in   8   store data
//   READDATA       out  8   load data (0 when READ is low)
//   BUSYWAIT       out  1   stall CPU / inhibit register write
//   MEM_READ       out  1   memory block read strobe
//   MEM_WRITE      out  1   memory block write strobe
//   MEM_ADDRESS    out  6   block address {tag, index}
//   MEM_WRITEDATA  out  32  victim block, byte 0 in [7:0]
//   MEM_READDATA   in   32  fetched block, byte 0 in [7:0]
//   MEM_BUSYWAIT   in   1   memory busy
//   HIT_COUNT      out  16  saturating hit counter   (CACHE_STATS_EN only)
//   MISS_COUNT     out  16  saturating miss counter  (CACHE_STATS_EN only)
//
// Handshakes (valid/ready)
//   CPU side:
//     READ/WRITE is the request valid; BUSYWAIT low is ready.
//     A request completes on the posedge where it is high and BUSYWAIT is
//     low. The CPU holds ADDRESS/WRITEDATA stable while BUSYWAIT is high.
//   Memory side:
//     MEM_READ/MEM_WRITE is valid; MEM_BUSYWAIT low is ready.
//     A transfer completes on the first posedge with the strobe high and
//     MEM_BUSYWAIT low. Strobe, MEM_ADDRESS and MEM_WRITEDATA hold until
//     then, and the two strobes are never high together.
// -----------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int SETS  = 8,
    parameter int IDX_W = 3,
    parameter int TAG_W = 3
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   READ,
    input  logic                   WRITE,
    input  logic [7:0]             ADDRESS,
    input  logic [7:0]             WRITEDATA,
    output logic [7:0]             READDATA,
    output logic                   BUSYWAIT,
    output logic                   MEM_READ,
    output logic                   MEM_WRITE,
    output logic [TAG_W+IDX_W-1:0] MEM_ADDRESS,
    output logic [31:0]            MEM_WRITEDATA,
    input  logic [31:0]            MEM_READDATA,
    input  logic                   MEM_BUSYWAIT
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]            HIT_COUNT,
    output logic [15:0]            MISS_COUNT
`endif
);

    // Controller state. Exposed as a named signal so that checkers can be
    // bound to it.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t state;

    // Storage. Only valid/dirty are reset; data and tags are qualified by
    // valid.
    logic [31:0]      line_mem [SETS];
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [SETS-1:0]  valid;
    logic [SETS-1:0]  dirty;

    // Address fields are decoded live from the CPU address.
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       offset;

    assign tag    = ADDRESS[7 -: TAG_W];
    assign idx    = ADDRESS[IDX_W+1:2];
    assign offset = ADDRESS[1:0];

    logic access;
    logic hit;
    logic write_hit;
    logic fill_done;

    // Index and tag of the block in flight. These come from the registered
    // memory address, so a line fill lands where the transfer was aimed.
    logic [IDX_W-1:0] xfer_idx;
    logic [TAG_W-1:0] xfer_tag;

    assign access    = READ | WRITE;
    assign hit       = valid[idx] && (tag_mem[idx] == tag);

    // READ together with WRITE counts as a store, because WRITE alone
    // decides whether the line is written.
    assign write_hit = (state == IDLE) && WRITE && hit;
    assign fill_done = (state == ALLOCATE) && !MEM_BUSYWAIT;

    assign xfer_idx  = MEM_ADDRESS[IDX_W-1:0];
    assign xfer_tag  = MEM_ADDRESS[IDX_W +: TAG_W];

    // -------------------------------------------------------------------------
    // CPU-facing outputs
    // -------------------------------------------------------------------------
    logic [31:0] sel_line;
    logic [7:0]  rd_byte;

    assign sel_line = line_mem[idx];

    always_comb begin
        rd_byte = 8'h00;
        case (offset)
            2'd0: rd_byte = sel_line[7:0];
            2'd1: rd_byte = sel_line[15:8];
            2'd2: rd_byte = sel_line[23:16];
            2'd3: rd_byte = sel_line[31:24];
            default: rd_byte = 8'h00;
        endcase
    end

    // Both outputs are forced low while reset is asserted. Otherwise a
    // request still held during reset would see every line invalid and
    // raise BUSYWAIT.
    assign READDATA = (RESET && READ) ? rd_byte : 8'h00;

    // BUSYWAIT rises in the same cycle as a miss is seen in IDLE, and stays
    // high through every non-IDLE state, including UPDATE.
    assign BUSYWAIT = RESET && ((state != IDLE) || (access && !hit));

    // -------------------------------------------------------------------------
    // Controller FSM
    // Owns state, valid/dirty and the registered memory strobes, address
    // and write data.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            valid         <= '0;
            dirty         <= '0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !hit) begin
                        if (valid[idx] && dirty[idx]) begin
                            state         <= WRITEBACK;
                            MEM_WRITE     <= 1'b1;
                            MEM_ADDRESS   <= {tag_mem[idx], idx};
                            MEM_WRITEDATA <= line_mem[idx];
                        end else begin
                            state       <= ALLOCATE;
                            MEM_READ    <= 1'b1;
                            MEM_ADDRESS <= {tag, idx};
                        end
                    end else if (write_hit) begin
                        dirty[idx] <= 1'b1;
                    end
                end

                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        // Memory now matches the victim line, so it is
                        // clean. If the request was dropped mid-miss, stop
                        // here and do not allocate.
                        MEM_WRITE       <= 1'b0;
                        dirty[xfer_idx] <= 1'b0;
                        if (access) begin
                            state       <= ALLOCATE;
                            MEM_READ    <= 1'b1;
                            MEM_ADDRESS <= {tag, idx};
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                ALLOCATE: begin
                    if (!MEM_BUSYWAIT) begin
                        MEM_READ        <= 1'b0;
                        valid[xfer_idx] <= 1'b1;
                        dirty[xfer_idx] <= 1'b0;
                        state           <= UPDATE;
                    end
                end

                UPDATE: begin
                    // Single settling cycle. The held request replays as a
                    // hit in IDLE.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Data and tag arrays (no reset)
    // A line fill and a store hit cannot coincide: they need different
    // states.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            line_mem[xfer_idx] <= MEM_READDATA;
            tag_mem[xfer_idx]  <= xfer_tag;
        end else if (write_hit) begin
            line_mem[idx][{offset, 3'b000} +: 8] <= WRITEDATA;
        end
    end

`ifdef CACHE_STATS_EN
    // -------------------------------------------------------------------------
    // Hit/miss statistics
    // The IDLE cycle right after UPDATE is the replay of an access that was
    // already counted as a miss, so it does not count as a hit.
    // -------------------------------------------------------------------------
    logic after_update;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            HIT_COUNT    <= 16'h0000;
            MISS_COUNT   <= 16'h0000;
            after_update <= 1'b0;
        end else begin
            after_update <= (state == UPDATE);

            if ((state == IDLE) && access && hit && !after_update &&
                (HIT_COUNT != 16'hFFFF)) begin
                HIT_COUNT <= HIT_COUNT + 16'd1;
            end

            if ((state == IDLE) && access && !hit &&
                (MISS_COUNT != 16'hFFFF)) begin
                MISS_COUNT <= MISS_COUNT + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
